ampel_xing: RTL and testbench



---
 rtl/ampel_pkg.sv | 34 +++
 rtl/ampel_timer.sv | 28 ++
 rtl/ampel_xing.sv | 233 +++++++++++++++++++++++
 tb/tb_ampel_xing.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ampel_pkg.sv
// Shared types and lamp encodings for the two-road intersection controller.
package ampel_pkg;

   // Controller states; ALL_RED_B doubles as the power-up state.
   typedef enum logic [3:0] {
      MAIN_GREEN,
      MAIN_YELLOW,
      ALL_RED_A,
      SIDE_REDYEL,
      SIDE_GREEN,
      SIDE_YELLOW,
      ALL_RED_B,
      MAIN_REDYEL,
      NIGHT_BLINK
   } state_t;

   // Vehicle lamp patterns: [2]=red, [1]=yellow, [0]=green.
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_RY  = 3'b110;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Pedestrian lamp patterns: [1]=red, [0]=green; 00 is dark.
   localparam logic [1:0] PED_STOP = 2'b10;
   localparam logic [1:0] PED_WALK = 2'b01;
   localparam logic [1:0] PED_DARK = 2'b00;

   // Larger of two integers, used to size the shared phase timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ampel_timer.sv
// Loadable down-counter: counts to zero and holds there, flagging done.
module ampel_timer #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [W-1:0]  i_load_val,
   output logic          o_done
);

   logic [W-1:0] r_count;

   // Load has priority; otherwise decrement until zero and stay there.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= RST_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/ampel_xing.sv
// Two-road intersection controller with pedestrian crossing over the main
// road, latched requests, minimum main green and night flashing-yellow mode.
module ampel_xing #(
   parameter int CLOCK_SIGNALS = 10,
   parameter int T_MIN_GREEN   = 5,
   parameter int T_GREEN_SIDE  = 8,
   parameter int T_YELLOW      = 3,
   parameter int T_REDYEL      = 1,
   parameter int T_ALLRED      = 2
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic       BTN,
   input  logic       SENSOR,
   input  logic       NIGHT,
   output logic [2:0] RGB_MAIN,
   output logic [2:0] RGB_SIDE,
   output logic [1:0] PED,
   output logic       REQ_PENDING
);
   import ampel_pkg::*;

   // Phase lengths in clock cycles.
   localparam int P_MIN_GREEN  = T_MIN_GREEN  * CLOCK_SIGNALS;
   localparam int P_GREEN_SIDE = T_GREEN_SIDE * CLOCK_SIGNALS;
   localparam int P_YELLOW     = T_YELLOW     * CLOCK_SIGNALS;
   localparam int P_REDYEL     = T_REDYEL     * CLOCK_SIGNALS;
   localparam int P_ALLRED     = T_ALLRED     * CLOCK_SIGNALS;
   localparam int P_MAX = max_int(max_int(max_int(P_MIN_GREEN, P_GREEN_SIDE),
                                          max_int(P_YELLOW, P_REDYEL)), P_ALLRED);
   localparam int TW = $clog2(P_MAX);

   // The timer is loaded with length-1 so a phase spans exactly length edges.
   localparam logic [TW-1:0] LD_MIN_GREEN  = TW'(P_MIN_GREEN  - 1);
   localparam logic [TW-1:0] LD_GREEN_SIDE = TW'(P_GREEN_SIDE - 1);
   localparam logic [TW-1:0] LD_YELLOW     = TW'(P_YELLOW     - 1);
   localparam logic [TW-1:0] LD_REDYEL     = TW'(P_REDYEL     - 1);
   localparam logic [TW-1:0] LD_ALLRED     = TW'(P_ALLRED     - 1);

   // Blink counter walks 0..CLOCK_SIGNALS-1; lamp lit for the first half.
   localparam int BW = $clog2(CLOCK_SIGNALS);
   localparam logic [BW-1:0] BLINK_LAST = BW'(CLOCK_SIGNALS - 1);
   localparam logic [BW-1:0] BLINK_HALF = BW'(CLOCK_SIGNALS / 2);

   state_t          r_state;
   state_t          w_state_next;
   logic            r_night_path;
   logic            r_ped_req;
   logic            r_side_req;
   logic            r_blink;
   logic [BW-1:0]   r_blink_cnt;
   logic [BW-1:0]   w_blink_cnt_next;
   logic            w_load;
   logic [TW-1:0]   w_load_val;
   logic            w_timer_done;
   logic            w_enter_side_green;

   ampel_timer #(
      .W       (TW),
      .RST_VAL (LD_ALLRED)
   ) u_timer (
      .i_clk      (CLK),
      .i_rst      (RES),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_timer_done)
   );

   // Next-state and timer-reload selection; each timed phase exits on expiry.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_val   = '0;
      case (r_state)
         MAIN_GREEN: begin
            // Timer holds at zero once minimum green is served.
            if (w_timer_done && (NIGHT || r_ped_req || r_side_req)) begin
               w_state_next = MAIN_YELLOW;
               w_load       = 1'b1;
               w_load_val   = LD_YELLOW;
            end
         end
         MAIN_YELLOW: begin
            if (w_timer_done) begin
               w_load = 1'b1;
               if (r_night_path) begin
                  w_state_next = NIGHT_BLINK;
               end else begin
                  w_state_next = ALL_RED_A;
                  w_load_val   = LD_ALLRED;
               end
            end
         end
         ALL_RED_A: begin
            if (w_timer_done) begin
               w_state_next = SIDE_REDYEL;
               w_load       = 1'b1;
               w_load_val   = LD_REDYEL;
            end
         end
         SIDE_REDYEL: begin
            if (w_timer_done) begin
               w_state_next = SIDE_GREEN;
               w_load       = 1'b1;
               w_load_val   = LD_GREEN_SIDE;
            end
         end
         SIDE_GREEN: begin
            if (w_timer_done) begin
               w_state_next = SIDE_YELLOW;
               w_load       = 1'b1;
               w_load_val   = LD_YELLOW;
            end
         end
         SIDE_YELLOW: begin
            if (w_timer_done) begin
               w_state_next = ALL_RED_B;
               w_load       = 1'b1;
               w_load_val   = LD_ALLRED;
            end
         end
         ALL_RED_B: begin
            if (w_timer_done) begin
               w_state_next = MAIN_REDYEL;
               w_load       = 1'b1;
               w_load_val   = LD_REDYEL;
            end
         end
         MAIN_REDYEL: begin
            if (w_timer_done) begin
               w_state_next = MAIN_GREEN;
               w_load       = 1'b1;
               w_load_val   = LD_MIN_GREEN;
            end
         end
         NIGHT_BLINK: begin
            // Leaving night mode always clears the junction with a full all-red.
            if (!NIGHT) begin
               w_state_next = ALL_RED_B;
               w_load       = 1'b1;
               w_load_val   = LD_ALLRED;
            end
         end
         default: begin
            w_state_next = ALL_RED_B;
            w_load       = 1'b1;
            w_load_val   = LD_ALLRED;
         end
      endcase
   end

   assign w_enter_side_green = (w_state_next == SIDE_GREEN) && (r_state != SIDE_GREEN);

   // State register plus the flag that routes MAIN_YELLOW into night mode.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_state      <= ALL_RED_B;
         r_night_path <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == MAIN_GREEN && w_state_next == MAIN_YELLOW) begin
            r_night_path <= NIGHT;
         end else if (r_state == MAIN_YELLOW && w_state_next != MAIN_YELLOW) begin
            r_night_path <= 1'b0;
         end
      end
   end

   // Request latches: serving the side phase clears them and beats a new set.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_ped_req  <= 1'b0;
         r_side_req <= 1'b0;
      end else if (w_enter_side_green) begin
         r_ped_req  <= 1'b0;
         r_side_req <= 1'b0;
      end else if (r_state != NIGHT_BLINK) begin
         if (BTN) begin
            r_ped_req <= 1'b1;
         end
         if (SENSOR) begin
            r_side_req <= 1'b1;
         end
      end
   end

   assign w_blink_cnt_next = (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + BW'(1);

   // Blink generator: parked at phase start outside night mode so it enters lit.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (r_state != NIGHT_BLINK) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else begin
         r_blink_cnt <= w_blink_cnt_next;
         r_blink     <= (w_blink_cnt_next < BLINK_HALF);
      end
   end

   // Moore lamp decode from the registered state and blink bit.
   always_comb begin
      RGB_MAIN = LAMP_RED;
      RGB_SIDE = LAMP_RED;
      PED      = PED_STOP;
      case (r_state)
         MAIN_GREEN:  RGB_MAIN = LAMP_GRN;
         MAIN_YELLOW: RGB_MAIN = LAMP_YEL;
         SIDE_REDYEL: RGB_SIDE = LAMP_RY;
         SIDE_GREEN: begin
            RGB_SIDE = LAMP_GRN;
            PED      = PED_WALK;
         end
         SIDE_YELLOW: RGB_SIDE = LAMP_YEL;
         MAIN_REDYEL: RGB_MAIN = LAMP_RY;
         NIGHT_BLINK: begin
            RGB_MAIN = r_blink ? LAMP_YEL : LAMP_OFF;
            RGB_SIDE = r_blink ? LAMP_YEL : LAMP_OFF;
            PED      = PED_DARK;
         end
         default: begin
            RGB_MAIN = LAMP_RED;
            RGB_SIDE = LAMP_RED;
            PED      = PED_STOP;
         end
      endcase
   end

   assign REQ_PENDING = r_ped_req | r_side_req;

endmodule

// File: tb/tb_ampel_xing.sv
// Scoreboard bench for ampel_xing: each scenario queues the lamp pattern
// expected after given rising edges; a monitor compares on falling edges.
module tb_ampel_xing;

   logic       CLK = 1'b0;
   logic       RES = 1'b0;
   logic       BTN = 1'b0;
   logic       SENSOR = 1'b0;
   logic       NIGHT = 1'b0;
   logic [2:0] RGB_MAIN;
   logic [2:0] RGB_SIDE;
   logic [1:0] PED;
   logic       REQ_PENDING;

   int cnt    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         edge_n;
      logic [2:0] m;
      logic [2:0] s;
      logic [1:0] p;
      logic       r;
      string      nm;
   } exp_t;

   exp_t q[$];

   ampel_xing #(
      .CLOCK_SIGNALS (10),
      .T_MIN_GREEN   (5),
      .T_GREEN_SIDE  (8),
      .T_YELLOW      (3),
      .T_REDYEL      (1),
      .T_ALLRED      (2)
   ) dut (
      .CLK         (CLK),
      .RES         (RES),
      .BTN         (BTN),
      .SENSOR      (SENSOR),
      .NIGHT       (NIGHT),
      .RGB_MAIN    (RGB_MAIN),
      .RGB_SIDE    (RGB_SIDE),
      .PED         (PED),
      .REQ_PENDING (REQ_PENDING)
   );

   always #5 CLK = ~CLK;

   // Edge number since reset release; 0 while reset is held.
   always @(posedge CLK or posedge RES) begin
      if (RES) cnt <= 0;
      else     cnt <= cnt + 1;
   end

   task automatic expect_at(input int n, input logic [2:0] m, input logic [2:0] s,
                            input logic [1:0] p, input logic r, input string nm);
      exp_t e;
      e.edge_n = n; e.m = m; e.s = s; e.p = p; e.r = r; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: compare the head of the queue when its edge has been reached.
   initial begin
      forever begin
         @(negedge CLK);
         if (q.size() > 0 && q[0].edge_n == cnt) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({RGB_MAIN, RGB_SIDE, PED, REQ_PENDING} !== {e.m, e.s, e.p, e.r}) begin
               errors++;
               $display("FAIL %s edge %0d: got main=%b side=%b ped=%b req=%b, want main=%b side=%b ped=%b req=%b",
                        e.nm, cnt, RGB_MAIN, RGB_SIDE, PED, REQ_PENDING, e.m, e.s, e.p, e.r);
            end else begin
               $display("ok   %s edge %0d: main=%b side=%b ped=%b req=%b",
                        e.nm, cnt, RGB_MAIN, RGB_SIDE, PED, REQ_PENDING);
            end
         end
      end
   end

   task automatic wait_cnt(input int n);
      int g;
      g = 0;
      while (cnt < n && g < 3000) begin
         @(negedge CLK);
         g++;
      end
      if (cnt < n) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt: edge %0d not reached, at %0d", n, cnt);
      end
   endtask

   task automatic apply_reset();
      @(posedge CLK);
      #2;
      RES = 1'b1;
      BTN = 1'b0;
      SENSOR = 1'b0;
      NIGHT = 1'b0;
      repeat (3) @(negedge CLK);
      RES = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() > 0 && g < 2000) begin
         @(negedge CLK);
         g++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %s edge %0d never checked, at %0d", q[0].nm, q[0].edge_n, cnt);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 RES = 1'b1;

      // A: power-up sequence with no inputs.
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "A_reset");
      expect_at(1,   3'b100, 3'b100, 2'b10, 1'b0, "A_allred_first");
      expect_at(19,  3'b100, 3'b100, 2'b10, 1'b0, "A_allred_last");
      expect_at(20,  3'b110, 3'b100, 2'b10, 1'b0, "A_redyel_first");
      expect_at(29,  3'b110, 3'b100, 2'b10, 1'b0, "A_redyel_last");
      expect_at(30,  3'b001, 3'b100, 2'b10, 1'b0, "A_green");
      expect_at(80,  3'b001, 3'b100, 2'b10, 1'b0, "A_green_idle");
      expect_at(150, 3'b001, 3'b100, 2'b10, 1'b0, "A_green_hold");
      apply_reset();
      drain();

      // B: pedestrian button after minimum green, full side cycle.
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "B_reset");
      expect_at(99,  3'b001, 3'b100, 2'b10, 1'b0, "B_pre_btn");
      expect_at(100, 3'b001, 3'b100, 2'b10, 1'b1, "B_latched");
      expect_at(101, 3'b010, 3'b100, 2'b10, 1'b1, "B_myel_first");
      expect_at(130, 3'b010, 3'b100, 2'b10, 1'b1, "B_myel_last");
      expect_at(131, 3'b100, 3'b100, 2'b10, 1'b1, "B_allred_a");
      expect_at(150, 3'b100, 3'b100, 2'b10, 1'b1, "B_allred_a_last");
      expect_at(151, 3'b100, 3'b110, 2'b10, 1'b1, "B_side_redyel");
      expect_at(160, 3'b100, 3'b110, 2'b10, 1'b1, "B_side_redyel_last");
      expect_at(161, 3'b100, 3'b001, 2'b01, 1'b0, "B_side_green");
      expect_at(240, 3'b100, 3'b001, 2'b01, 1'b0, "B_side_green_last");
      expect_at(241, 3'b100, 3'b010, 2'b10, 1'b0, "B_side_yel");
      expect_at(270, 3'b100, 3'b010, 2'b10, 1'b0, "B_side_yel_last");
      expect_at(271, 3'b100, 3'b100, 2'b10, 1'b0, "B_allred_b");
      expect_at(290, 3'b100, 3'b100, 2'b10, 1'b0, "B_allred_b_last");
      expect_at(291, 3'b110, 3'b100, 2'b10, 1'b0, "B_main_redyel");
      expect_at(300, 3'b110, 3'b100, 2'b10, 1'b0, "B_main_redyel_last");
      expect_at(301, 3'b001, 3'b100, 2'b10, 1'b0, "B_main_green");
      apply_reset();
      wait_cnt(99);  BTN = 1'b1;
      wait_cnt(100); BTN = 1'b0;
      drain();

      // C: early sensor held until min green; re-latch during side green.
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "C_reset");
      expect_at(35,  3'b001, 3'b100, 2'b10, 1'b1, "C_early_latch");
      expect_at(79,  3'b001, 3'b100, 2'b10, 1'b1, "C_min_green_held");
      expect_at(80,  3'b010, 3'b100, 2'b10, 1'b1, "C_myel_at_80");
      expect_at(110, 3'b100, 3'b100, 2'b10, 1'b1, "C_allred_a");
      expect_at(130, 3'b100, 3'b110, 2'b10, 1'b1, "C_side_redyel");
      expect_at(140, 3'b100, 3'b001, 2'b01, 1'b0, "C_clear_wins");
      expect_at(149, 3'b100, 3'b001, 2'b01, 1'b0, "C_side_green_idle");
      expect_at(150, 3'b100, 3'b001, 2'b01, 1'b1, "C_relatch");
      expect_at(219, 3'b100, 3'b001, 2'b01, 1'b1, "C_side_green_last");
      expect_at(220, 3'b100, 3'b010, 2'b10, 1'b1, "C_side_yel");
      expect_at(250, 3'b100, 3'b100, 2'b10, 1'b1, "C_allred_b");
      expect_at(270, 3'b110, 3'b100, 2'b10, 1'b1, "C_main_redyel");
      expect_at(280, 3'b001, 3'b100, 2'b10, 1'b1, "C_main_green");
      expect_at(329, 3'b001, 3'b100, 2'b10, 1'b1, "C_main_green_last");
      expect_at(330, 3'b010, 3'b100, 2'b10, 1'b1, "C_second_myel");
      expect_at(390, 3'b100, 3'b001, 2'b01, 1'b0, "C_second_side_green");
      apply_reset();
      wait_cnt(34);  SENSOR = 1'b1;
      wait_cnt(35);  SENSOR = 1'b0;
      wait_cnt(139); BTN = 1'b1;
      wait_cnt(140); BTN = 1'b0;
      wait_cnt(149); SENSOR = 1'b1;
      wait_cnt(155); SENSOR = 1'b0;
      drain();

      // D: night mode entry, blinking, ignored inputs, and exit.
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "D_reset");
      expect_at(79,  3'b001, 3'b100, 2'b10, 1'b0, "D_min_green");
      expect_at(80,  3'b010, 3'b100, 2'b10, 1'b0, "D_myel");
      expect_at(109, 3'b010, 3'b100, 2'b10, 1'b0, "D_myel_last");
      expect_at(110, 3'b010, 3'b010, 2'b00, 1'b0, "D_blink_on_first");
      expect_at(114, 3'b010, 3'b010, 2'b00, 1'b0, "D_blink_on_last");
      expect_at(115, 3'b000, 3'b000, 2'b00, 1'b0, "D_blink_off_first");
      expect_at(119, 3'b000, 3'b000, 2'b00, 1'b0, "D_blink_off_last");
      expect_at(120, 3'b010, 3'b010, 2'b00, 1'b0, "D_blink_on_again");
      expect_at(130, 3'b010, 3'b010, 2'b00, 1'b0, "D_btn_ignored");
      expect_at(131, 3'b010, 3'b010, 2'b00, 1'b0, "D_sensor_ignored");
      expect_at(149, 3'b000, 3'b000, 2'b00, 1'b0, "D_blink_off_before_exit");
      expect_at(150, 3'b100, 3'b100, 2'b10, 1'b0, "D_allred_b");
      expect_at(169, 3'b100, 3'b100, 2'b10, 1'b0, "D_allred_b_last");
      expect_at(170, 3'b110, 3'b100, 2'b10, 1'b0, "D_main_redyel");
      expect_at(180, 3'b001, 3'b100, 2'b10, 1'b0, "D_main_green");
      apply_reset();
      wait_cnt(39);  NIGHT = 1'b1;
      wait_cnt(129); BTN = 1'b1;
      wait_cnt(130); BTN = 1'b0; SENSOR = 1'b1;
      wait_cnt(131); SENSOR = 1'b0;
      wait_cnt(149); NIGHT = 1'b0;
      drain();

      // E: asynchronous reset in the middle of side green.
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "E_reset");
      expect_at(161, 3'b100, 3'b001, 2'b01, 1'b0, "E_side_green");
      expect_at(190, 3'b100, 3'b001, 2'b01, 1'b1, "E_relatch");
      expect_at(200, 3'b100, 3'b001, 2'b01, 1'b1, "E_before_reset");
      expect_at(0,   3'b100, 3'b100, 2'b10, 1'b0, "E_async_reset");
      expect_at(1,   3'b100, 3'b100, 2'b10, 1'b0, "E_allred_first");
      expect_at(19,  3'b100, 3'b100, 2'b10, 1'b0, "E_allred_last");
      expect_at(20,  3'b110, 3'b100, 2'b10, 1'b0, "E_redyel");
      expect_at(30,  3'b001, 3'b100, 2'b10, 1'b0, "E_green");
      apply_reset();
      wait_cnt(99);  BTN = 1'b1;
      wait_cnt(100); BTN = 1'b0;
      wait_cnt(189); SENSOR = 1'b1;
      wait_cnt(190); SENSOR = 1'b0;
      wait_cnt(200);
      apply_reset();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
